// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, keeps at most one request
// outstanding to instruction memory, steers the next PC through the static
// branch predictor and buffers {pc, instr} pairs in a 2-entry queue for decode.
// A flush redirects the PC, empties the queue and drops any response that
// belongs to a request issued before the flush.
module ifu_fetch_ctrl #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}},
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  // instruction memory
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  // static branch predictor
  output logic [XLEN-1:0] bpu_pc_o,
  output logic [31:0]     bpu_instr_o,
  input  logic [XLEN-1:0] bpu_pc_pred_i,
  // redirect from execute
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_addr_i,
  // decode side
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [31:0]     id_instr_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [XLEN-1:0]     inflight_q, inflight_d;

  logic [1:0][XLEN-1:0] ent_pc_q;
  logic [1:0][31:0]     ent_instr_q;
  logic [1:0]           count_q, count_d;
  logic                 rd_ptr_q;
  logic                 wr_ptr_q;

  logic                 enq_s;
  logic                 deq_s;

  // Word alignment drops the low address bits of redirect and prediction.
  logic [1:0]           unused_low_bits_s;
  assign unused_low_bits_s = flush_addr_i[1:0] ^ bpu_pc_pred_i[1:0];

  // Queue handshakes and the occupancy that will hold after the coming edge.
  always_comb begin
    enq_s   = (state_q == ST_WAIT) && imem_rvalid_i && !flush_i;
    deq_s   = (count_q != 2'd0) && id_ready_i && !flush_i;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      count_d = count_q + {1'b0, enq_s} - {1'b0, deq_s};
    end
  end

  // Fetch sequencing: next state, next PC and the address of the in-flight fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_gnt_i) begin
          inflight_d = pc_q;
          state_d    = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          pc_d    = {bpu_pc_pred_i[XLEN-1:2], 2'b00};
          state_d = (count_d <= 2'd1) ? ST_REQ : ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (count_d <= 2'd1) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A redirect overrides everything; a request the memory has already
    // taken (or is taking now) must be drained before issuing again.
    if (flush_i) begin
      pc_d = {flush_addr_i[XLEN-1:2], 2'b00};
      case (state_q)
        ST_WAIT:  state_d = imem_rvalid_i ? ST_REQ : ST_DRAIN;
        ST_REQ:   state_d = imem_gnt_i    ? ST_DRAIN : ST_REQ;
        ST_DRAIN: state_d = imem_rvalid_i ? ST_REQ : ST_DRAIN;
        default:  state_d = ST_REQ;
      endcase
    end else begin
      pc_d = pc_d;
    end
  end

  // FSM state, fetch PC and in-flight PC registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= {XLEN{1'b0}};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
    end
  end

  // Two-entry fetch queue toward decode; pointers wrap naturally at one bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_pc_q    <= {(2*XLEN){1'b0}};
      ent_instr_q <= {64{1'b0}};
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (enq_s) begin
          ent_pc_q[wr_ptr_q]    <= inflight_q;
          ent_instr_q[wr_ptr_q] <= imem_rdata_i;
          wr_ptr_q              <= wr_ptr_q + 1'b1;
        end
        if (deq_s) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  assign imem_req_o  = (state_q == ST_REQ);
  assign imem_addr_o = pc_q;

  assign bpu_pc_o    = inflight_q;
  assign bpu_instr_o = imem_rdata_i;

  assign id_valid_o  = (count_q != 2'd0);
  assign id_pc_o     = id_valid_o ? ent_pc_q[rd_ptr_q]    : {XLEN{1'b0}};
  assign id_instr_o  = id_valid_o ? ent_instr_q[rd_ptr_q] : NOP_INSTR;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference
// (expected fetch PC, outstanding-request flag and a queue of {pc, instr}).
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] bpu_pc;
  logic [31:0] bpu_instr;
  logic [31:0] bpu_pc_pred;
  logic        flush;
  logic [31:0] flush_addr;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  ifu_fetch_ctrl #(
    .XLEN(32), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .bpu_pc_o(bpu_pc), .bpu_instr_o(bpu_instr), .bpu_pc_pred_i(bpu_pc_pred),
    .flush_i(flush), .flush_addr_i(flush_addr),
    .id_valid_o(id_valid), .id_ready_i(id_ready),
    .id_pc_o(id_pc), .id_instr_o(id_instr)
  );

  always #5 clk = ~clk;

  // Static predictor: JAL taken, backward conditional branch taken, else pc+4.
  function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] ins);
    logic [31:0] imm;
    predict = pc + 32'd4;
    if (ins[6:0] == 7'b1101111) begin
      imm     = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      predict = pc + imm;
    end else if (ins[6:0] == 7'b1100011) begin
      imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      if (ins[31]) predict = pc + imm;
    end
  endfunction

  always_comb bpu_pc_pred = predict(bpu_pc, bpu_instr);

  // Reference model state.
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_out_pc;
  bit          m_out;
  bit          m_disc;
  int          pushes;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc     = RESET_PC;
    m_out_pc = 32'h0;
    m_out    = 1'b0;
    m_disc   = 1'b0;
  endtask

  // Apply one cycle of inputs (called just after a falling edge), check the
  // outputs against the model, then advance the model to the next rising edge.
  task automatic step(input bit g, input bit rv, input logic [31:0] rd,
                      input bit rdy, input bit fl, input logic [31:0] fa);
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    id_ready    = rdy;
    flush       = fl;
    flush_addr  = fa;
    #1;
    check_eq("id_valid", {31'b0, id_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      check_eq("id_pc", id_pc, q[0].pc);
      check_eq("id_instr", id_instr, q[0].instr);
    end else begin
      check_eq("id_pc_empty", id_pc, 32'h0);
      check_eq("id_instr_empty", id_instr, NOP);
    end
    if (imem_req) begin
      check_eq("req_addr", imem_addr, m_pc);
      check_eq("req_single_outstanding", {31'b0, m_out}, 32'h0);
      check_eq("req_room", {31'b0, q.size() <= 1}, 32'h1);
    end
    if (rv && !m_disc && !fl) begin
      check_eq("bpu_pc", bpu_pc, m_out_pc);
      check_eq("bpu_instr", bpu_instr, rd);
    end
    if (fl) begin
      q.delete();
      m_pc = {fa[31:2], 2'b00};
      if (imem_req && g) begin
        m_out = 1'b1; m_disc = 1'b1;
      end else if (rv) begin
        m_out = 1'b0; m_disc = 1'b0;
      end else if (m_out) begin
        m_disc = 1'b1;
      end
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (rv) begin
        if (!m_disc) begin
          q.push_back('{pc: m_out_pc, instr: rd});
          m_pc = predict(m_out_pc, rd) & 32'hFFFF_FFFC;
          pushes++;
        end
        m_out = 1'b0; m_disc = 1'b0;
      end
      if (imem_req && g) begin
        m_out = 1'b1; m_disc = 1'b0; m_out_pc = m_pc;
      end
    end
  endtask

  task automatic cyc(input bit g, input bit rv, input logic [31:0] rd,
                     input bit rdy, input bit fl, input logic [31:0] fa);
    @(negedge clk);
    step(g, rv, rd, rdy, fl, fa);
  endtask

  // Redirect to tgt, fetch one instruction there, check the predicted follow-on.
  task automatic redirect_fetch(input logic [31:0] tgt, input logic [31:0] ins,
                                input logic [31:0] nxt);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, tgt);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("redir_addr", imem_addr, tgt);
    cyc(1'b0, 1'b1, ins, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("pred_req", {31'b0, imem_req}, 32'h1);
    check_eq("pred_addr", imem_addr, nxt);
    check_eq("pred_id_pc", id_pc, tgt);
    check_eq("pred_id_instr", id_instr, ins);
  endtask

  task automatic drive_idle();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    id_ready = 1'b0; flush = 1'b0; flush_addr = 32'h0;
  endtask

  logic [31:0] r_word;
  logic [31:0] r_ins;
  bit          r_g, r_rv, r_rdy, r_fl;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pushes = 0;
    rst_n  = 1'b0;
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_req", {31'b0, imem_req}, 32'h0);
    check_eq("rst_addr", imem_addr, RESET_PC);
    check_eq("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check_eq("rst_id_pc", id_pc, 32'h0);
    check_eq("rst_id_instr", id_instr, NOP);
    check_eq("rst_bpu_pc", bpu_pc, 32'h0);

    // Sequential fetch with single-cycle grant and response.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      check_eq("seq_req", {31'b0, imem_req}, 32'h1);
      check_eq("seq_addr", imem_addr, 32'(4 * i));
      if (i == 1) begin
        check_eq("lat_valid", {31'b0, id_valid}, 32'h1);
        check_eq("lat_pc", id_pc, 32'h0);
        check_eq("lat_instr", id_instr, 32'h0000_0013);
      end
      cyc(1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
    end

    // Prediction: JAL, backward branch taken, forward branch not taken.
    redirect_fetch(32'h10, 32'h0080_006F, 32'h18);
    redirect_fetch(32'h20, 32'hFE00_0EE3, 32'h1C);
    redirect_fetch(32'h20, 32'h0000_0463, 32'h24);

    // Backpressure: queue fills, fetch stops, one dequeue restarts it.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h1111_1013, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("bp_addr2", imem_addr, 32'h28);
    cyc(1'b0, 1'b1, 32'h2222_2013, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("bp_hold_req", {31'b0, imem_req}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("bp_hold_req2", {31'b0, imem_req}, 32'h0);
    check_eq("bp_head_pc", id_pc, 32'h24);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("bp_resume_req", {31'b0, imem_req}, 32'h1);
    check_eq("bp_order_pc", id_pc, 32'h28);
    check_eq("bp_order_instr", id_instr, 32'h2222_2013);

    // Flush while waiting: drain the late response, restart at 0x100.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h103);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("fl_valid", {31'b0, id_valid}, 32'h0);
    check_eq("fl_drain_req", {31'b0, imem_req}, 32'h0);
    cyc(1'b0, 1'b1, 32'hDEAD_0013, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("fl_restart_req", {31'b0, imem_req}, 32'h1);
    check_eq("fl_restart_addr", imem_addr, 32'h100);
    check_eq("fl_discard", {31'b0, id_valid}, 32'h0);

    // Flush coinciding with the response: dropped, refetch 0x100.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b1, 32'h101);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("flrv_valid", {31'b0, id_valid}, 32'h0);
    check_eq("flrv_req", {31'b0, imem_req}, 32'h1);
    check_eq("flrv_addr", imem_addr, 32'h100);

    // Asynchronous reset while draining.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
    @(negedge clk);
    drive_idle();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_req", {31'b0, imem_req}, 32'h0);
    check_eq("arst_addr", imem_addr, RESET_PC);
    check_eq("arst_valid", {31'b0, id_valid}, 32'h0);
    check_eq("arst_id_instr", id_instr, NOP);
    check_eq("arst_bpu_pc", bpu_pc, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("arst_restart_req", {31'b0, imem_req}, 32'h1);
    check_eq("arst_restart_addr", imem_addr, RESET_PC);
    cyc(1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);

    // Randomized traffic against the reference model.
    pushes = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      r_word = $urandom;
      case ($urandom_range(0, 3))
        0:       r_ins = r_word;
        1:       r_ins = {r_word[31:7], 7'b1101111};
        2:       r_ins = {r_word[31:7], 7'b1100011};
        default: r_ins = 32'h0000_0013;
      endcase
      r_g   = imem_req && ($urandom_range(0, 1) == 1);
      r_rv  = m_out && ($urandom_range(0, 4) < 2);
      r_rdy = ($urandom_range(0, 2) != 0);
      r_fl  = ($urandom_range(0, 19) == 0);
      step(r_g, r_rv, r_ins, r_rdy, r_fl, $urandom);
    end
    check_eq("random_progress", {31'b0, pushes > 200}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
